mod_mul_barrett_pipeline: RTL and testbench
===========================================

# mod_mul_barrett_pipeline

Pipelined modular multiplier computing (a·b) mod q with Barrett reduction for the Kyber NTT datapath. It sits directly upstream of the pipelined modular adder/subtractor in the butterfly and produces the twiddle product zeta·b that the adder combines with the other operand. It is fully pipelined, accepts one operand pair per enabled cycle, and has a fixed latency with a valid strobe alongside the data.

## Interface
- DATA_WIDTH, 12, coefficient width; inputs and result are unsigned.
- MODULUS, 3329, modulus q; requires q < 2^DATA_WIDTH.
- clk  input  1  single clock; all logic on the rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- enable  input  1  global advance; 0 freezes every pipeline register.
- valid_in  input  1  a/b valid this cycle; sampled only when enable=1.
- a  input  DATA_WIDTH  operand, expected in [0, q).
- b  input  DATA_WIDTH  operand (twiddle), expected in [0, q).
- result  output  DATA_WIDTH  (a·b) mod q, in [0, q).
- valid_out  output  1  result valid; one cycle per accepted input.
- busy  output  1  OR of all internal stage valid bits and valid_out.

## Operation
- Barrett constants: K = 2·DATA_WIDTH (24); M = floor(2^K / q) (5039 for q=3329).
- S1: p = a·b, 2·DATA_WIDTH bits. No truncation, because (q−1)^2 < 2^24.
- S2: t = (p·M) >> K, DATA_WIDTH+1 bits. Full-width intermediate product (24×13 bits).
- S3: r = p − t·q, computed mod 2^(DATA_WIDTH+2). The result is guaranteed in [0, 2q).
- S4: result = (r ≥ q) ? r − q : r. Exactly one conditional subtraction.
- Each stage carries its valid bit. Data in a stage whose valid bit is 0 is don't-care, but it must not cause X on result.
- enable=0: all stage registers, valid bits, result and valid_out hold their values. No input is accepted.
- valid_out stays high while enable=0 and the held output is valid. The consumer qualifies it with enable.
- Order is strictly preserved; there is no reordering or dropping.
- Reset (rst_n=0 at an edge): every stage valid bit, valid_out, busy and result go to 0 regardless of enable. In-flight operations are discarded, so no stale valid_out appears after reset.
- Inputs ≥ q: the result is undefined but bounded to DATA_WIDTH bits. It is flagged only when the checker is configured in.

## Timing
- Latency: 4 enabled cycles. An input sampled at edge n (enable=1) appears on result/valid_out after edge n+3, counted in enabled edges.
- Throughput: 1 per enabled cycle; no back-pressure output.
- Reset values: result=0, valid_out=0, busy=0, range_err=0.
- busy drops to 0 on the edge where the last valid leaves valid_out.
- rst_n and enable both low: reset wins.

## Configuration
- MOD_MUL_RANGE_CHECK_EN defined:
  - Adds output range_err (1 bit).
  - range_err is set sticky on the edge where enable=1, valid_in=1 and either a ≥ MODULUS or b ≥ MODULUS.
  - It is cleared only by reset. The datapath is unchanged.
- Not defined: there is no range_err port and no checking logic.

## Structure
- Shared package kyber_arith_pkg holds:
  - KYBER_Q = 3329, the coefficient width, BARRETT_K and BARRETT_M as localparams.
  - A function computing BARRETT_M from q and K.
- One sub-module, barrett_reduce: the S2–S4 registered reduction with valid passthrough and enable hold. The same block is reused by later reduction stages.
- The top level holds the S1 multiplier register, the busy logic and the optional range checker.

## Test plan
- a=0, b=1234, valid 1 cycle → result=0, valid_out high for exactly 1 cycle, 4 cycles later.
- a=3328, b=3328 → 1. a=17, b=17 → 289. a=1000, b=2000 → 2600, back-to-back on consecutive cycles, outputs in the same order on consecutive cycles.
- Stream of 8 random pairs with enable=0 for 3 cycles mid-stream → every result equals the reference model, delayed by exactly 3 cycles past the stall, with no duplicates or drops. Result and valid_out are held during the stall.
- rst_n=0 for 1 cycle while 3 ops are in flight → valid_out=0, result=0, busy=0 from the next cycle, with no valid_out until new inputs arrive.
- Exhaustive a∈[0,3328], b∈{1, 17, 3328, random}: every result < 3329 and matches (a·b)%3329.
- With MOD_MUL_RANGE_CHECK_EN: a=3329, b=5, valid → range_err=1 next cycle, staying 1 through further legal inputs until reset. Without the macro, the same stimulus compiles with no range_err port.

Source files
------------

// File: rtl/kyber_arith_pkg.sv
// -----------------------------------------------------------------------------
// kyber_arith_pkg
// Shared arithmetic constants for the Kyber NTT datapath:
//   KYBER_Q           coefficient modulus q
//   KYBER_DATA_WIDTH  coefficient width in bits
//   BARRETT_K         Barrett shift, 2 * coefficient width
//   BARRETT_M         Barrett multiplier floor(2^K / q)
//   barrett_m()       derives the Barrett multiplier for any (q, K)
// -----------------------------------------------------------------------------
package kyber_arith_pkg;

  localparam int unsigned KYBER_Q          = 3329;
  localparam int unsigned KYBER_DATA_WIDTH = 12;
  localparam int unsigned BARRETT_K        = 2 * KYBER_DATA_WIDTH;

  // floor(2^k / q). Evaluated at elaboration time only. The 64-bit width
  // covers every coefficient width up to 31 bits.
  function automatic longint unsigned barrett_m(input longint unsigned q,
                                                input int unsigned       k);
    return (64'd1 << k) / q;
  endfunction

  localparam int unsigned BARRETT_M = 32'(barrett_m(64'(KYBER_Q), BARRETT_K));

endpackage : kyber_arith_pkg

// File: rtl/barrett_reduce.sv
// -----------------------------------------------------------------------------
// barrett_reduce
// Three-stage registered Barrett reduction of a 2*DATA_WIDTH-bit product p
// to p mod MODULUS. Each stage carries a valid bit, and every register holds
// its value while i_enable is low.
//   S2: t = (p * M) >> K
//   S3: r = p - t*q   (mod 2^(DATA_WIDTH+2)), r in [0, 2q)
//   S4: result = (r >= q) ? r - q : r
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   i_enable        pipeline advance; 0 freezes every register
//   i_valid         i_p valid this cycle
//   i_p             unreduced product, 2*DATA_WIDTH bits
//   o_result        reduced value in [0, MODULUS)
//   o_valid         o_result valid
//   o_stage_valid   {S3 valid, S2 valid}, used for the parent's busy flag
// -----------------------------------------------------------------------------
module barrett_reduce
  import kyber_arith_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = KYBER_DATA_WIDTH,
  parameter int unsigned MODULUS    = KYBER_Q
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_enable,
  input  logic                      i_valid,
  input  logic [2*DATA_WIDTH-1:0]   i_p,
  output logic [DATA_WIDTH-1:0]     o_result,
  output logic                      o_valid,
  output logic [1:0]                o_stage_valid
);

  localparam int unsigned K    = 2 * DATA_WIDTH;
  localparam int unsigned M    = 32'(barrett_m(64'(MODULUS), K));
  // t never exceeds M, so it fits in the width of M itself.
  localparam int unsigned T_W  = $clog2(M + 1);
  localparam int unsigned PM_W = K + T_W;
  localparam int unsigned TQ_W = T_W + DATA_WIDTH;
  // r < 2q < 2^(DATA_WIDTH+1); one extra guard bit keeps the modular
  // subtraction unambiguous.
  localparam int unsigned R_W  = DATA_WIDTH + 2;

  localparam logic [T_W-1:0]        M_VEC = T_W'(M);
  localparam logic [DATA_WIDTH-1:0] Q_D   = DATA_WIDTH'(MODULUS);
  localparam logic [R_W-1:0]        Q_R   = R_W'(MODULUS);

  // ---------------------------------------------------------------- S2
  logic [PM_W-1:0] w_pm;
  logic [T_W-1:0]  w_t;

  assign w_pm = PM_W'(i_p) * PM_W'(M_VEC);
  assign w_t  = T_W'(w_pm >> K);

  logic [T_W-1:0] r_t;
  logic [R_W-1:0] r_p_lo;
  logic           r_v2;

  // Only the low R_W bits of p are needed further down, because S3 works
  // modulo 2^R_W.
  // NOTE: data registers are reset along with the valid bits so that a bubble
  // never carries X into result; it costs one reset mux per bit, no memories.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_t    <= '0;
      r_p_lo <= '0;
      r_v2   <= 1'b0;
    end else if (i_enable) begin
      r_t    <= w_t;
      r_p_lo <= i_p[R_W-1:0];
      r_v2   <= i_valid;
    end
  end

  // ---------------------------------------------------------------- S3
  logic [R_W-1:0] w_tq;
  logic [R_W-1:0] w_r;

  assign w_tq = R_W'(TQ_W'(r_t) * TQ_W'(Q_D));
  assign w_r  = r_p_lo - w_tq;

  logic [R_W-1:0] r_r;
  logic           r_v3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_r  <= '0;
      r_v3 <= 1'b0;
    end else if (i_enable) begin
      r_r  <= w_r;
      r_v3 <= r_v2;
    end
  end

  // ---------------------------------------------------------------- S4
  logic [DATA_WIDTH-1:0] w_res;

  // A single conditional subtraction is enough because r < 2q.
  assign w_res = (r_r >= Q_R) ? DATA_WIDTH'(r_r - Q_R) : r_r[DATA_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_result <= '0;
      o_valid  <= 1'b0;
    end else if (i_enable) begin
      o_result <= w_res;
      o_valid  <= r_v3;
    end
  end

  assign o_stage_valid = {r_v3, r_v2};

endmodule : barrett_reduce

// File: rtl/mod_mul_barrett_pipeline.sv
// -----------------------------------------------------------------------------
// mod_mul_barrett_pipeline
// Fully pipelined modular multiplier result = (a*b) mod MODULUS, feeding the
// modular adder/subtractor of the Kyber NTT butterfly. Latency is 4 enabled
// cycles with one operand pair accepted per enabled cycle.
//   S1 (here)             p = a*b, full 2*DATA_WIDTH bits
//   S2..S4 (barrett_reduce) Barrett reduction of p
// Ports:
//   clk, rst_n     clock, synchronous active-low reset (wins over enable)
//   enable         global advance; 0 freezes every pipeline register
//   valid_in       a/b valid; sampled only when enable=1
//   a, b           operands, expected in [0, MODULUS)
//   result         (a*b) mod MODULUS
//   valid_out      result valid (held while enable=0)
//   busy           OR of every stage valid bit and valid_out
//   range_err      sticky flag for an accepted operand >= MODULUS; present
//                  only when MOD_MUL_RANGE_CHECK_EN is defined
// MODULUS must be below 2^DATA_WIDTH.
// -----------------------------------------------------------------------------
module mod_mul_barrett_pipeline
  import kyber_arith_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = KYBER_DATA_WIDTH,
  parameter int unsigned MODULUS    = KYBER_Q
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  valid_out,
  output logic                  busy
`ifdef MOD_MUL_RANGE_CHECK_EN
  ,
  output logic                  range_err
`endif
);

  localparam int unsigned P_W = 2 * DATA_WIDTH;

  // ---------------------------------------------------------------- S1
  // (q-1)^2 < 2^P_W, so the full product needs no truncation. Operands that
  // are out of range still fit, which keeps the result bounded.
  logic [P_W-1:0] w_p;

  assign w_p = P_W'(a) * P_W'(b);

  logic [P_W-1:0] r_p;
  logic           r_v1;

  // NOTE: state is updated with non-blocking assignments only, so every stage
  // samples its predecessor's value from before the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_p  <= '0;
      r_v1 <= 1'b0;
    end else if (enable) begin
      r_p  <= w_p;
      r_v1 <= valid_in;
    end
  end

  // ---------------------------------------------------------- S2..S4
  logic [1:0] w_stage_valid;

  barrett_reduce #(
    .DATA_WIDTH (DATA_WIDTH),
    .MODULUS    (MODULUS)
  ) u_reduce (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_enable      (enable),
    .i_valid       (r_v1),
    .i_p           (r_p),
    .o_result      (result),
    .o_valid       (valid_out),
    .o_stage_valid (w_stage_valid)
  );

  // All terms are registers, so busy falls on the same edge that clears the
  // last valid_out, and it is 0 straight out of reset.
  assign busy = r_v1 | (|w_stage_valid) | valid_out;

`ifdef MOD_MUL_RANGE_CHECK_EN
  // ------------------------------------------------------ range checker
  localparam logic [DATA_WIDTH-1:0] Q_D = DATA_WIDTH'(MODULUS);

  // Observes only accepted inputs. The datapath itself is unaffected.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      range_err <= 1'b0;
    end else if (enable && valid_in && ((a >= Q_D) || (b >= Q_D))) begin
      range_err <= 1'b1;
    end
  end
`endif

endmodule : mod_mul_barrett_pipeline

// File: tb/tb_mod_mul_barrett_pipeline.sv
// -----------------------------------------------------------------------------
// tb_mod_mul_barrett_pipeline
// Self-checking bench for mod_mul_barrett_pipeline. Inputs are driven and
// outputs sampled on the falling clock edge. A scoreboard queue holds the
// expected results in order. A monitor pops one entry for every valid_out
// produced by an edge where the pipeline advanced. An entry of -1 is
// don't-care (out-of-range operands).
// -----------------------------------------------------------------------------
module tb_mod_mul_barrett_pipeline;

  localparam int Q = 3329;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        valid_in;
  logic [11:0] a;
  logic [11:0] b;
  logic [11:0] result;
  logic        valid_out;
  logic        busy;
`ifdef MOD_MUL_RANGE_CHECK_EN
  logic        range_err;
`endif

  mod_mul_barrett_pipeline dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .valid_in  (valid_in),
    .a         (a),
    .b         (b),
    .result    (result),
    .valid_out (valid_out),
    .busy      (busy)
`ifdef MOD_MUL_RANGE_CHECK_EN
    ,
    .range_err (range_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model(input int x, input int y);
    return (x * y) % Q;
  endfunction

  // ------------------------------------------------------------ scoreboard
  int   exp_q[$];
  logic en_sampled = 1'b0;

  always @(posedge clk) en_sampled <= enable && rst_n;

  always @(negedge clk) begin
    int e;
    if (en_sampled && valid_out) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid_out", 32'(valid_out), 32'd0);
      end else begin
        e = exp_q.pop_front();
        if (e >= 0) begin
          check("result", 32'(result), 32'(e));
          check("result_lt_q", 32'(result < 12'(Q)), 32'd1);
        end
      end
    end
  end

  // Sets inputs for the next rising edge, then moves to the next falling edge.
  task automatic drive(input logic v, input int ia, input int ib, input int ex,
                       input logic en, input logic rn);
    valid_in = v;
    a        = 12'(ia);
    b        = 12'(ib);
    enable   = en;
    rst_n    = rn;
    if (v && en && rn) exp_q.push_back(ex);
    @(negedge clk);
    if (!rn) exp_q.delete();
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 0, 1'b1, 1'b1);
  endtask

  task automatic drain();
    int budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      idle();
      budget--;
    end
    idle();
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    check("drain_busy", 32'(busy), 32'd0);
  endtask

  typedef struct {
    int a;
    int b;
    int exp;
  } vec_t;

  vec_t vecs[13];

  logic [11:0] hold_res;
  logic        hold_v;
  int          sa[8];
  int          sb[8];
  int          bs[4];

  initial begin
    vecs[0]  = '{0,    1234, 0};
    vecs[1]  = '{3328, 3328, 1};
    vecs[2]  = '{17,   17,   289};
    vecs[3]  = '{1000, 2000, 2600};
    vecs[4]  = '{3328, 1,    3328};
    vecs[5]  = '{1234, 1,    1234};
    vecs[6]  = '{3328, 2,    3327};
    vecs[7]  = '{2,    1665, 1};
    vecs[8]  = '{100,  100,  13};
    vecs[9]  = '{1665, 1665, 2497};
    vecs[10] = '{3000, 3000, 1713};
    vecs[11] = '{1729, 17,   2761};
    vecs[12] = '{2048, 2048, 3093};

    valid_in = 1'b0;
    a        = '0;
    b        = '0;

    // Reset with enable low: reset must still win.
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_valid_out", 32'(valid_out), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
`ifdef MOD_MUL_RANGE_CHECK_EN
    check("reset_range_err", 32'(range_err), 32'd0);
`endif
    idle();

    // Single op: valid_out appears after the 4th enabled edge, for one cycle.
    drive(1'b1, 0, 1234, 0, 1'b1, 1'b1);
    check("lat_busy_s1", 32'(busy), 32'd1);
    check("lat_vout_e0", 32'(valid_out), 32'd0);
    idle();
    check("lat_vout_e1", 32'(valid_out), 32'd0);
    idle();
    check("lat_vout_e2", 32'(valid_out), 32'd0);
    idle();
    check("lat_vout_e3", 32'(valid_out), 32'd1);
    check("lat_result_e3", 32'(result), 32'd0);
    check("lat_busy_e3", 32'(busy), 32'd1);
    idle();
    check("lat_vout_e4", 32'(valid_out), 32'd0);
    check("lat_busy_e4", 32'(busy), 32'd0);

    // Directed table, back-to-back on consecutive cycles.
    for (int i = 0; i < 13; i++) drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1, 1'b1);
    drain();

    // Stream of 8 pairs with a 3-cycle stall in the middle. Stall-cycle
    // inputs carry valid_in=1 and must not be accepted.
    for (int i = 0; i < 8; i++) begin
      sa[i] = int'($urandom_range(0, Q - 1));
      sb[i] = int'($urandom_range(0, Q - 1));
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        hold_res = result;
        hold_v   = valid_out;
        for (int s = 0; s < 3; s++) begin
          drive(1'b1, 7, 9, 0, 1'b0, 1'b1);
          check("stall_hold_result", 32'(result), 32'(hold_res));
          check("stall_hold_valid", 32'(valid_out), 32'(hold_v));
        end
      end
      drive(1'b1, sa[i], sb[i], model(sa[i], sb[i]), 1'b1, 1'b1);
    end
    drain();

    // Reset while 3 ops are in flight: nothing may emerge afterwards.
    drive(1'b1, 3328, 3328, 1, 1'b1, 1'b1);
    drive(1'b1, 17, 17, 289, 1'b1, 1'b1);
    drive(1'b1, 1000, 2000, 2600, 1'b1, 1'b1);
    drive(1'b0, 0, 0, 0, 1'b1, 1'b0);
    check("flush_valid_out", 32'(valid_out), 32'd0);
    check("flush_result", 32'(result), 32'd0);
    check("flush_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 6; i++) begin
      idle();
      check("flush_no_stale_valid", 32'(valid_out), 32'd0);
    end

    // Sweep a over [0, q) against a few fixed twiddles and one random one.
    bs[0] = 1;
    bs[1] = 17;
    bs[2] = 3328;
    bs[3] = int'($urandom_range(2, Q - 2));
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < Q; i++) drive(1'b1, i, bs[j], model(i, bs[j]), 1'b1, 1'b1);
    drain();

`ifdef MOD_MUL_RANGE_CHECK_EN
    // An out-of-range operand sets the sticky flag; only reset clears it.
    check("range_err_before", 32'(range_err), 32'd0);
    drive(1'b1, 3329, 5, -1, 1'b1, 1'b1);
    check("range_err_set", 32'(range_err), 32'd1);
    drive(1'b1, 17, 17, 289, 1'b1, 1'b1);
    drive(1'b1, 3328, 3328, 1, 1'b1, 1'b1);
    check("range_err_sticky", 32'(range_err), 32'd1);
    drain();
    check("range_err_still", 32'(range_err), 32'd1);
    drive(1'b0, 0, 0, 0, 1'b1, 1'b0);
    check("range_err_cleared", 32'(range_err), 32'd0);
    idle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_mod_mul_barrett_pipeline
